mem_port_master: RTL

MEM_PORT_MASTER -- requirements
Module: mem_port_master

---
 rtl/mem_port_master_pkg.sv | 37 +++
 rtl/mem_port_merge.sv | 25 ++
 rtl/mem_port_master.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_master_pkg.sv
// Shared types and width helpers for the memory port master.
// Defaults match the 64-bit word, 64-entry RAM configuration.
package mem_port_master_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int DEPTH_DEF      = 64;
    localparam int ADDR_WIDTH_DEF = 64;

    // Derived widths for the default configuration
    localparam int IDX_W  = $clog2(DEPTH_DEF);
    localparam int L      = $clog2(DATA_WIDTH_DEF / 8);
    localparam int STRB_W = DATA_WIDTH_DEF / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_CAP,
        WR,
        RMW_RD,
        RMW_MRG,
        RMW_WR,
        RESP
    } state_e;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int lane_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/mem_port_merge.sv
// Byte-lane merge: strobed bytes come from the new data,
// all other bytes keep the old RAM contents.
module mem_port_merge
    import mem_port_master_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int SW = strb_width(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [SW-1:0]         wstrb_i,
    output logic [DATA_WIDTH-1:0] merged_o
);

    // Select each byte lane by its strobe
    always_comb begin
        merged_o = old_i;
        for (int b = 0; b < SW; b++) begin
            if (wstrb_i[b]) begin
                merged_o[8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_port_master.sv
// Single-outstanding request port to a synchronous single-port RAM.
// Partial-strobe writes are done as read-merge-write.
module mem_port_master
    import mem_port_master_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    localparam int IW = idx_width(DEPTH),
    localparam int BL = lane_bits(DATA_WIDTH),
    localparam int SW = strb_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [SW-1:0]         req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  ram_cs_n,
    output logic                  ram_we,
    output logic [IW-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    state_e                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  cs_n_q, cs_n_d;
    logic                  we_q, we_d;
    logic [IW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;

    logic [DATA_WIDTH-1:0] merged;
    logic [IW-1:0]         req_idx;
    logic                  addr_err;

    assign req_idx  = req_addr[IW+BL-1:BL];
    assign addr_err = (req_addr >> (IW + BL)) != '0;

    mem_port_merge #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_merge (
        .wdata_i  (wdata_q),
        .old_i    (ram_dout),
        .wstrb_i  (wstrb_q),
        .merged_o (merged)
    );

    // Next state and next registered outputs
    always_comb begin
        state_d  = state_q;
        cs_n_d   = 1'b1;
        we_d     = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (addr_err) begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rdata_d  = '0;
                        err_d    = 1'b1;
                    end else if (!req_we) begin
                        state_d = RD;
                        cs_n_d  = 1'b0;
                        addr_d  = req_idx;
                    end else if (&req_wstrb) begin
                        state_d = WR;
                        cs_n_d  = 1'b0;
                        we_d    = 1'b1;
                        addr_d  = req_idx;
                        din_d   = req_wdata;
                    end else if (~|req_wstrb) begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rdata_d  = '0;
                        err_d    = 1'b0;
                    end else begin
                        state_d = RMW_RD;
                        cs_n_d  = 1'b0;
                        addr_d  = req_idx;
                    end
                end
            end
            RD:      state_d = RD_CAP;
            RD_CAP: begin
                state_d  = RESP;
                rvalid_d = 1'b1;
                rdata_d  = ram_dout;
                err_d    = 1'b0;
            end
            WR, RMW_WR: begin
                state_d  = RESP;
                rvalid_d = 1'b1;
                rdata_d  = '0;
                err_d    = 1'b0;
            end
            RMW_RD:  state_d = RMW_MRG;
            RMW_MRG: begin
                state_d = RMW_WR;
                cs_n_d  = 1'b0;
                we_d    = 1'b1;
                din_d   = merged;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            cs_n_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            cs_n_q   <= cs_n_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
        end
    end

    assign req_ready  = ready_q;
    assign ram_cs_n   = cs_n_q;
    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign ram_din    = din_q;
    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
